// File: rtl/sd_pkg.sv
// Shared definitions for the SD block buffer: FSM states, block geometry
// and controller op codes.
package sd_pkg;

    localparam int unsigned BLOCK_BYTES = 512;
    localparam int unsigned ADDR_W      = 9;   // byte index inside one block
    localparam int unsigned PTR_W       = 10;  // byte pointer, one extra bit to express "full"

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(BLOCK_BYTES);

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ISSUE        = 3'd1,
        ST_WAIT_ACCEPT  = 3'd2,
        ST_READ_STREAM  = 3'd3,
        ST_WRITE_STREAM = 3'd4,
        ST_FINISH       = 3'd5
    } state_t;

    // Stream state entered once the controller has accepted the command.
    function automatic state_t stream_state(input logic op);
        return (op == OP_READ) ? ST_READ_STREAM : ST_WRITE_STREAM;
    endfunction

endpackage

// File: rtl/sd_byte_ram.sv
// 512x8 block buffer: one write port, one registered read port for the host
// and one asynchronous read port feeding the card controller.
module sd_byte_ram
    import sd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    input  logic [ADDR_W-1:0] araddr,
    output logic [7:0]        ardata
);

    logic [7:0] mem [BLOCK_BYTES];

    // Storage array write port.
    // NOTE: the array itself has no reset; clearing 512 bytes would need a
    // sequencer, and the contents are defined by whoever writes them next.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Host read port: one cycle latency, returns the value before a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

    assign ardata = mem[araddr];

endmodule

// File: rtl/sd_block_buffer.sv
// Single-block buffer between a host and an SD card controller. The host fills
// or drains the buffer while idle; the FSM moves one 512-byte block to or from
// the controller, guarded by a per-transfer watchdog.
module sd_block_buffer
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    // host side
    input  logic              cmd_read,
    input  logic              cmd_write,
    input  logic [31:0]       lba,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic              host_we,
    output logic [7:0]        host_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    // card controller side
    output logic              op_code,
    output logic              execute,
    output logic [31:0]       block_address,
    output logic [7:0]        outgoing_byte,
    input  logic [7:0]        incoming_byte,
    input  logic              finished_byte,
    input  logic              finished_block,
    input  logic              ctrl_busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [WD_W-1:0]   watchdog, watchdog_next;
    logic              error_next;
    logic              op_next;
    logic [31:0]       addr_next;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_ardata;

    sd_byte_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (host_addr),
        .rdata  (host_rdata),
        .araddr (ptr[ADDR_W-1:0]),
        .ardata (ram_ardata)
    );

    // FSM state register.
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath updates and buffer write-port arbitration.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        watchdog_next = watchdog;
        error_next    = error;
        op_next       = op_code;
        addr_next     = block_address;
        ram_we        = 1'b0;
        ram_waddr     = host_addr;
        ram_wdata     = host_wdata;

        unique case (state)
            ST_IDLE: begin
                ram_we        = host_we;
                watchdog_next = '0;
                // Read has priority when both commands arrive together.
                if (cmd_read || cmd_write) begin
                    op_next    = cmd_read ? OP_READ : OP_WRITE;
                    addr_next  = lba;
                    error_next = 1'b0;
                    ptr_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ctrl_busy) begin
                    state_next = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (ctrl_busy) begin
                    state_next = stream_state(op_code);
                end
            end
            ST_READ_STREAM: begin
                // The byte is handled before any same-cycle block termination.
                if (finished_byte) begin
                    if (ptr < PTR_FULL) begin
                        ram_we    = 1'b1;
                        ram_waddr = ptr[ADDR_W-1:0];
                        ram_wdata = incoming_byte;
                        ptr_next  = ptr + 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                if (finished_block) begin
                    state_next = ST_FINISH;
                    if (ptr_next != PTR_FULL) begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_WRITE_STREAM: begin
                if (finished_byte && (ptr < PTR_FULL)) begin
                    ptr_next = ptr + 1'b1;
                end
                if (finished_block) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Watchdog runs for the whole transfer; FINISH is already on its way out.
        if (state != ST_IDLE) begin
            watchdog_next = watchdog + 1'b1;
            if ((state != ST_FINISH) && (watchdog == WD_LAST)) begin
                error_next = 1'b1;
                state_next = ST_FINISH;
            end
        end
    end

    // Datapath registers; execute is registered from the next state so it is
    // high exactly while waiting for the controller to accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= '0;
            watchdog      <= '0;
            error         <= 1'b0;
            op_code       <= OP_READ;
            block_address <= '0;
            execute       <= 1'b0;
        end else begin
            ptr           <= ptr_next;
            watchdog      <= watchdog_next;
            error         <= error_next;
            op_code       <= op_next;
            block_address <= addr_next;
            execute       <= (state_next == ST_WAIT_ACCEPT);
        end
    end

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FINISH);
    assign outgoing_byte = (ptr == PTR_FULL) ? 8'hFF : ram_ardata;

endmodule

// File: tb/tb_sd_block_buffer.sv
module tb_sd_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_read = 1'b0, cmd_write = 1'b0;
    logic [31:0] lba = '0;
    logic [8:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_we = 1'b0;
    logic [7:0]  host_rdata;
    logic        busy, done, error, op_code, execute;
    logic [31:0] block_address;
    logic [7:0]  outgoing_byte;
    logic [7:0]  incoming_byte = '0;
    logic        finished_byte = 1'b0, finished_block = 1'b0, ctrl_busy = 1'b0;

    // Second instance with a short watchdog.
    logic        t_cmd_read = 1'b0;
    logic [7:0]  t_host_rdata, t_outgoing_byte;
    logic        t_busy, t_done, t_error, t_op_code, t_execute;
    logic [31:0] t_block_address;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_mem [512];

    always #5 clk = ~clk;

    sd_block_buffer #(.TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_read(cmd_read), .cmd_write(cmd_write), .lba(lba),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .host_rdata(host_rdata), .busy(busy), .done(done), .error(error),
        .op_code(op_code), .execute(execute), .block_address(block_address),
        .outgoing_byte(outgoing_byte), .incoming_byte(incoming_byte),
        .finished_byte(finished_byte), .finished_block(finished_block),
        .ctrl_busy(ctrl_busy)
    );

    sd_block_buffer #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .cmd_read(t_cmd_read), .cmd_write(1'b0), .lba(32'h0000_0077),
        .host_addr(9'd0), .host_wdata(8'h00), .host_we(1'b0),
        .host_rdata(t_host_rdata), .busy(t_busy), .done(t_done), .error(t_error),
        .op_code(t_op_code), .execute(t_execute), .block_address(t_block_address),
        .outgoing_byte(t_outgoing_byte), .incoming_byte(8'h00),
        .finished_byte(1'b0), .finished_block(1'b0), .ctrl_busy(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic host_write(input logic [8:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Pulse a command for one cycle; returns after the accepting edge.
    task automatic start_cmd(input logic rd, input logic wr, input logic [31:0] a);
        cmd_read = rd; cmd_write = wr; lba = a;
        @(negedge clk);
        cmd_read = 1'b0; cmd_write = 1'b0;
    endtask

    task automatic handshake(input string tag, input logic exp_op, input logic [31:0] exp_lba);
        int n = 0;
        while (execute !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_execute_seen"}, execute, 1);
        check({tag, "_op_code"}, op_code, exp_op);
        check({tag, "_block_address"}, block_address, exp_lba);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_execute_held"}, execute, 1);
        ctrl_busy = 1'b1;
        @(negedge clk);
        check({tag, "_execute_dropped"}, execute, 0);
    endtask

    // Deliver n read bytes value i^key; optionally end with finished_block on the last byte.
    task automatic read_bytes(input int n, input logic [7:0] key, input bit block_on_last,
                              input bit poke_cmd_write);
        for (int i = 0; i < n; i++) begin
            incoming_byte = 8'(i) ^ key;
            finished_byte = 1'b1;
            finished_block = (block_on_last && i == n - 1);
            cmd_write = (poke_cmd_write && i == 10);
            exp_mem[i] = 8'(i) ^ key;
            @(negedge clk);
        end
        finished_byte = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic end_block(input string tag, input logic exp_err, input bit already_sent);
        if (!already_sent) begin
            finished_block = 1'b1;
            @(negedge clk);
        end
        finished_block = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, exp_err);
        ctrl_busy = 1'b0;
        @(negedge clk);
        check({tag, "_done_once"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic readback(input string tag);
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            host_addr = 9'(i);
            @(negedge clk);
            if (host_rdata !== exp_mem[i]) bad++;
        end
        check({tag, "_readback_mismatches"}, bad, 0);
    endtask

    initial begin
        int bad;
        int k;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_execute", execute, 0);
        check("rst_op_code", op_code, 0);
        check("rst_block_address", block_address, 0);
        check("rst_host_rdata", host_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Block write: pattern 0x00..0xFF repeated
        for (int i = 0; i < 512; i++) begin
            host_write(9'(i), 8'(i));
            exp_mem[i] = 8'(i);
        end
        start_cmd(1'b0, 1'b1, 32'h10);
        handshake("wr", 1'b1, 32'h10);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (outgoing_byte !== exp_mem[i]) bad++;
            // Host write attempted mid-transfer must be ignored.
            host_we = (i == 0);
            host_addr = 9'd5;
            host_wdata = 8'h77;
            finished_byte = 1'b1;
            @(negedge clk);
        end
        host_we = 1'b0;
        check("wr_outgoing_mismatches", bad, 0);
        check("wr_outgoing_saturated", outgoing_byte, 8'hFF);
        @(negedge clk);  // one surplus pulse at ptr=512
        finished_byte = 1'b0;
        check("wr_outgoing_still_ff", outgoing_byte, 8'hFF);
        end_block("wr", 1'b0, 1'b0);
        host_addr = 9'd5;
        @(negedge clk);
        check("wr_host_we_ignored", host_rdata, 8'h05);

        // Full read with byte+block in the same cycle; cmd_write poked mid-stream
        start_cmd(1'b1, 1'b0, 32'h20);
        handshake("rd", 1'b0, 32'h20);
        read_bytes(512, 8'hA5, 1'b1, 1'b1);
        end_block("rd", 1'b0, 1'b1);
        check("rd_op_code_kept", op_code, 0);
        readback("rd");

        // Short read: block ends after 300 bytes
        start_cmd(1'b1, 1'b0, 32'h30);
        handshake("short", 1'b0, 32'h30);
        read_bytes(300, 8'h5A, 1'b0, 1'b0);
        end_block("short", 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("short_error_sticky", error, 1);

        // Next read clears error, then reset lands at byte 100
        start_cmd(1'b1, 1'b0, 32'h40);
        check("clear_error_on_cmd", error, 0);
        handshake("abort", 1'b0, 32'h40);
        read_bytes(100, 8'h11, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ctrl_busy = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_execute", execute, 0);
        check("abort_done", done, 0);

        // Fresh read with both commands in one cycle: read wins
        start_cmd(1'b1, 1'b1, 32'h55);
        handshake("both", 1'b0, 32'h55);
        read_bytes(512, 8'h3C, 1'b0, 1'b0);
        end_block("both", 1'b0, 1'b0);
        readback("both");

        // Overflow: a 513th byte is discarded and flags error
        start_cmd(1'b1, 1'b0, 32'h66);
        handshake("ovf", 1'b0, 32'h66);
        read_bytes(512, 8'hC3, 1'b0, 1'b0);
        incoming_byte = 8'hEE;
        finished_byte = 1'b1;
        @(negedge clk);
        finished_byte = 1'b0;
        end_block("ovf", 1'b1, 1'b0);
        readback("ovf");

        // Watchdog: controller never raises ctrl_busy, limit 64
        t_cmd_read = 1'b1;
        @(negedge clk);
        t_cmd_read = 1'b0;
        k = 0;
        while (t_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 63) check("to_execute_before", t_execute, 1);
        end
        check("to_done_cycle", k, 64);
        check("to_error", t_error, 1);
        check("to_execute_dropped", t_execute, 0);
        @(negedge clk);
        check("to_idle", t_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
